// File: rtl/delay_sched_pkg.sv
// rtl/delay_sched_pkg.sv - shared state type, timebase constant and width helper for delay_scheduler
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // 10 ms tick at a 50 MHz clock
    localparam int TICK_DIV_10MS = 500_000;

    // Number of bits needed to hold the value; never less than 1
    function automatic int clogb2(input int value);
        int v;
        int w;
        v = value;
        w = 0;
        for (int k = 0; k < 32; k++) begin
            if (v > 0) begin
                w = w + 1;
                v = v >> 1;
            end
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_scheduler_tick_prescaler.sv
// rtl/delay_scheduler_tick_prescaler.sv - mod-TICK_DIV counter producing the shared delay tick
module tick_prescaler
    import delay_sched_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_10MS
) (
    input  logic CLOCK_50,
    input  logic aclr_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = clogb2(TICK_DIV - 1);
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Count 0..TICK_DIV-1 while enabled; clear wins over counting
    always_ff @(posedge CLOCK_50 or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= '0;
        end else if (enable) begin
            if (clear || (count == LAST)) begin
                count <= '0;
            end else begin
                count <= count + PW'(1);
            end
        end
    end

    // Tick is the enabled cycle on which the counter sits at its last value
    assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/delay_scheduler.sv
// rtl/delay_scheduler.sv - round-robin shared delay timer; DELAY_SCHED_CANCEL_EN adds cancel/aborted
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = TICK_DIV_10MS,
    parameter int DUR_W    = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  aclr_n,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DUR_W-1:0] dur,
    input  logic [NREQ-1:0]       cancel,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  aborted,
    output logic                  active,
    output logic [DUR_W-1:0]      remaining
);

    localparam int IDX_W = clogb2(NREQ - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  pick;
    logic              any_req;
    logic              tick;
    logic              cancel_hit;
    logic [DUR_W-1:0]  dur_sel;
    logic [NREQ-1:0]   grant_next;
    logic [NREQ-1:0]   done_next;
    logic              aborted_next;
    logic              active_next;
    logic [DUR_W-1:0]  remaining_next;

    // Prescaler only runs during RUN so every delay starts on a fresh tick period
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .aclr_n   (aclr_n),
        .clear    (state != RUN),
        .enable   (enable),
        .tick     (tick)
    );

    // Round-robin pick: first requester found after last_grant, wrapping
    always_comb begin
        any_req = 1'b0;
        pick    = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_req && req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
                    any_req = 1'b1;
                    pick    = IDX_W'(i);
                end
            end
        end
    end

    // Duration slice of the current owner
    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDX_W'(i)) begin
                dur_sel = dur[i*DUR_W +: DUR_W];
            end
        end
    end

`ifdef DELAY_SCHED_CANCEL_EN
    // Only the owner's cancel counts, and only while the delay is loading or running
    always_comb begin
        cancel_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if ((owner == IDX_W'(i)) && cancel[i] && ((state == LOAD) || (state == RUN))) begin
                cancel_hit = 1'b1;
            end
        end
    end
`else
    logic unused_cancel;
    assign unused_cancel = |cancel;
    assign cancel_hit    = 1'b0;
`endif

    // State register; a low enable freezes the sequence
    always_ff @(posedge CLOCK_50 or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (any_req) state_next = LOAD;
            LOAD: if (cancel_hit || (dur_sel == '0)) state_next = FIN;
                  else state_next = RUN;
            RUN:  if (cancel_hit || (tick && (remaining == DUR_W'(1)))) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        grant_next     = grant;
        done_next      = '0;
        aborted_next   = 1'b0;
        remaining_next = remaining;
        active_next    = (state_next != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        grant_next[i] = (pick == IDX_W'(i));
                    end
                end
            end
            LOAD: remaining_next = dur_sel;
            RUN: begin
                if (tick && (remaining != '0)) begin
                    remaining_next = remaining - DUR_W'(1);
                end
            end
            FIN: grant_next = '0;
            default: grant_next = '0;
        endcase
        if ((state != FIN) && (state_next == FIN)) begin
            for (int i = 0; i < NREQ; i++) begin
                done_next[i] = (owner == IDX_W'(i));
            end
            aborted_next = cancel_hit;
        end
        if (cancel_hit) begin
            remaining_next = '0;
        end
    end

    // Owner capture at grant and round-robin pointer update on completion
    always_ff @(posedge CLOCK_50 or negedge aclr_n) begin
        if (!aclr_n) begin
            owner      <= '0;
            last_grant <= IDX_W'(NREQ - 1);
        end else if (enable) begin
            if ((state == IDLE) && any_req) begin
                owner <= pick;
            end
            if (state == FIN) begin
                last_grant <= owner;
            end
        end
    end

    // Output registers; done/aborted are forced low when frozen so the pulse stays one cycle
    always_ff @(posedge CLOCK_50 or negedge aclr_n) begin
        if (!aclr_n) begin
            grant     <= '0;
            done      <= '0;
            aborted   <= 1'b0;
            remaining <= '0;
            active    <= 1'b0;
        end else if (enable) begin
            grant     <= grant_next;
            done      <= done_next;
            aborted   <= aborted_next;
            remaining <= remaining_next;
            active    <= active_next;
        end else begin
            done    <= '0;
            aborted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// tb/tb_delay_scheduler.sv - scoreboard bench for delay_scheduler (NREQ=4, TICK_DIV=4, DUR_W=8)
module tb_delay_scheduler;

    localparam int NREQ     = 4;
    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 8;

    typedef struct {
        logic [NREQ-1:0] d;
        logic            ab;
        int              c;
    } exp_t;

    logic                  clk;
    logic                  aclr_n;
    logic                  enable;
    logic [NREQ-1:0]       req;
    logic [NREQ*DUR_W-1:0] dur;
    logic [NREQ-1:0]       cancel;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  aborted;
    logic                  active;
    logic [DUR_W-1:0]      remaining;

    int   cyc;
    int   checks;
    int   errors;
    int   c0;
    exp_t exp_q[$];

    delay_scheduler #(
        .NREQ     (NREQ),
        .TICK_DIV (TICK_DIV),
        .DUR_W    (DUR_W)
    ) dut (
        .CLOCK_50  (clk),
        .aclr_n    (aclr_n),
        .enable    (enable),
        .req       (req),
        .dur       (dur),
        .cancel    (cancel),
        .grant     (grant),
        .done      (done),
        .aborted   (aborted),
        .active    (active),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] d, input logic ab, input int c);
        exp_t e;
        e.d  = d;
        e.ab = ab;
        e.c  = c;
        exp_q.push_back(e);
    endtask

    task automatic set_dur(input int i, input int v);
        dur[i*DUR_W +: DUR_W] = DUR_W'(v);
    endtask

    task automatic wait_done_drop(input int i, input int max);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            @(negedge clk);
            if (done[i]) seen = 1'b1;
        end
        req[i] = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done[%0d]: got timeout expected done pulse", i);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (aclr_n && (done != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected: got done=%b aborted=%b at cycle %0d expected none", done, aborted, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((done !== e.d) || (aborted !== e.ab) || (cyc != e.c)) begin
                    errors++;
                    $display("FAIL monitor_done: got done=%b aborted=%b cycle=%0d expected done=%b aborted=%b cycle=%0d",
                             done, aborted, cyc, e.d, e.ab, e.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        aclr_n = 1'b0;
        enable = 1'b1;
        req    = '0;
        dur    = '0;
        cancel = '0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_aborted", 32'(aborted), 0);
        aclr_n = 1'b1;
        @(negedge clk);

        // Single request: req[2], dur=3 -> done 13 edges after grant
        req[2] = 1'b1;
        set_dur(2, 3);
        c0 = cyc + 1;
        push(4'b0100, 1'b0, c0 + 13);
        @(negedge clk);
        chk("s1_grant", 32'(grant), 32'b0100);
        chk("s1_active", 32'(active), 1);
        @(negedge clk);
        chk("s1_rem3", 32'(remaining), 3);
        repeat (4) @(negedge clk);
        chk("s1_rem2", 32'(remaining), 2);
        repeat (4) @(negedge clk);
        chk("s1_rem1", 32'(remaining), 1);
        repeat (4) @(negedge clk);
        chk("s1_rem0", 32'(remaining), 0);
        chk("s1_done", 32'(done), 32'b0100);
        req[2] = 1'b0;
        @(negedge clk);
        chk("s1_idle_grant", 32'(grant), 0);
        chk("s1_idle_active", 32'(active), 0);

        // Contention from reset: grants 0,1,2,3,0 every 7 cycles
        aclr_n = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_dur(i, 1);
        c0 = cyc + 1;
        push(4'b0001, 1'b0, c0 + 5);
        push(4'b0010, 1'b0, c0 + 12);
        push(4'b0100, 1'b0, c0 + 19);
        push(4'b1000, 1'b0, c0 + 26);
        push(4'b0001, 1'b0, c0 + 33);
        @(negedge clk);
        chk("s2_grant0", 32'(grant), 32'b0001);
        repeat (6) @(negedge clk);
        chk("s2_gap", 32'(grant), 0);
        @(negedge clk);
        chk("s2_grant1", 32'(grant), 32'b0010);
        repeat (26) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        chk("s2_idle", 32'(active), 0);

        // Zero duration: req[1], dur=0 -> done on edge after grant
        req[1] = 1'b1;
        set_dur(1, 0);
        c0 = cyc + 1;
        push(4'b0010, 1'b0, c0 + 1);
        @(negedge clk);
        chk("s3_grant", 32'(grant), 32'b0010);
        chk("s3_rem_a", 32'(remaining), 0);
        @(negedge clk);
        chk("s3_rem_b", 32'(remaining), 0);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Enable dropped in FIN: done still lasts one cycle
        req[3] = 1'b1;
        set_dur(3, 0);
        c0 = cyc + 1;
        push(4'b1000, 1'b0, c0 + 1);
        @(negedge clk);
        chk("s4_grant", 32'(grant), 32'b1000);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("s4_done_low", 32'(done), 0);
        chk("s4_grant_held", 32'(grant), 32'b1000);
        repeat (2) @(negedge clk);
        req[3] = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("s4_released", 32'(grant), 0);
        @(negedge clk);

        // Enable pause of 7 cycles mid-RUN: dur=2 done moves from 9 to 16 edges
        req[0] = 1'b1;
        set_dur(0, 2);
        c0 = cyc + 1;
        push(4'b0001, 1'b0, c0 + 16);
        @(negedge clk);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("s5_rem_frozen", 32'(remaining), 2);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        wait_done_drop(0, 20);
        repeat (2) @(negedge clk);

`ifdef DELAY_SCHED_CANCEL_EN
        // Cancel: non-owner ignored, owner cancel ends the delay with aborted
        req[1] = 1'b1;
        set_dur(1, 10);
        c0 = cyc + 1;
        push(4'b0010, 1'b1, c0 + 6);
        @(negedge clk);
        repeat (2) @(negedge clk);
        cancel[2] = 1'b1;
        @(negedge clk);
        cancel[2] = 1'b0;
        chk("s7_nonowner", 32'(active), 1);
        repeat (2) @(negedge clk);
        cancel[1] = 1'b1;
        @(negedge clk);
        cancel[1] = 1'b0;
        req[1] = 1'b0;
        chk("s7_rem_cleared", 32'(remaining), 0);
        repeat (2) @(negedge clk);
`endif

        // Asynchronous reset mid-RUN, then req[0] and req[3] contend
        req[2] = 1'b1;
        set_dur(2, 5);
        repeat (6) @(negedge clk);
        #3;
        aclr_n = 1'b0;
        #1;
        chk("s6_grant", 32'(grant), 0);
        chk("s6_done", 32'(done), 0);
        chk("s6_active", 32'(active), 0);
        chk("s6_remaining", 32'(remaining), 0);
        chk("s6_aborted", 32'(aborted), 0);
        req = '0;
        @(negedge clk);
        aclr_n = 1'b1;
        req[0] = 1'b1;
        req[3] = 1'b1;
        set_dur(0, 1);
        set_dur(3, 1);
        c0 = cyc + 1;
        push(4'b0001, 1'b0, c0 + 5);
        push(4'b1000, 1'b0, c0 + 12);
        @(negedge clk);
        chk("s6_first", 32'(grant), 32'b0001);
        wait_done_drop(0, 20);
        wait_done_drop(3, 20);
        repeat (3) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shares a single 10 ms-timebase delay timer among NREQ requesters. Each requester asks for a delay of N ticks. A round-robin arbiter grants the timer to one requester at a time; a prescaler divides CLOCK_50 into ticks; a down-counter runs the delay, then pulses done to the owner. Sits between the system sequencers and the delay timebase, replacing per-user fixed delay instances.

## Interface
- NREQ, 4: number of requesters (2..8).
- TICK_DIV, 500_000: CLOCK_50 cycles per tick (10 ms at 50 MHz); minimum 2.
- DUR_W, 8: width of each duration field, in ticks.
- CLOCK_50  in  1  system clock, 50 MHz.
- aclr_n  in  1  asynchronous reset, active-low.
- enable  in  1  global run enable. Low freezes the prescaler, counter, FSM and arbiter; outputs hold.
- req  in  NREQ  per-requester request level.
- dur  in  NREQ*DUR_W  requested tick count; slice i is dur[i*DUR_W +: DUR_W].
- cancel  in  NREQ  abort request (only with DELAY_SCHED_CANCEL_EN).
- grant  out  NREQ  one-hot owner of the timer; all-zero when idle.
- done  out  NREQ  one-cycle completion pulse to the owner.
- aborted  out  1  pulses with done when the delay was cancelled; constant 0 without the macro.
- active  out  1  high when the FSM is not in IDLE.
- remaining  out  DUR_W  ticks left in the current delay; 0 when idle.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE: if enable and any req, the arbiter picks a requester and the FSM goes to LOAD, setting grant[i].
- Arbiter: round-robin. Search starts at last_grant+1 (mod NREQ). The reset value of last_grant is NREQ-1, so req[0] wins first after reset.
- LOAD: remaining <= dur slice i (captured once; later dur changes are ignored). Prescaler is cleared.
  - dur == 0: next state is FIN.
  - Otherwise: next state is RUN.
- RUN: the prescaler counts 0..TICK_DIV-1 and emits a tick on TICK_DIV-1, then wraps to 0. On each tick, remaining decrements. A tick with remaining == 1 goes to FIN (remaining becomes 0).
- FIN: done[i] is high for exactly this one cycle and grant[i] is still high. Next state is IDLE; grant clears and last_grant <= i.
- Requester protocol:
  - Hold req[i] and dur[i] stable until done[i].
  - Drop req the cycle after done. A req still high is re-arbitrated behind the other requesters.
- req[i] dropped while granted: ignored; the delay completes and done still pulses.
- Simultaneous requests: only one is granted; the others wait. They are never lost as long as req is held.
- Width rules:
  - Prescaler width is clogb2(TICK_DIV-1).
  - remaining is unsigned DUR_W and never underflows.
- Reset (async, any state): FSM to IDLE. grant, done, aborted, remaining, prescaler and active all go to 0. last_grant goes to NREQ-1.

## Timing
- Request to grant: req rises before edge E0 while IDLE → grant high after E0.
- Grant to done: the edge that sets done is exactly dur*TICK_DIV + 1 enabled edges after the edge that sets grant.
- dur = 0: done is set on the first edge after grant.
- Back-to-back: the next grant rises 1 cycle after done falls (one IDLE cycle between owners).
- enable low: all counts pause, and the latency extends by exactly the number of disabled cycles. done never stretches past 1 cycle: if enable drops in FIN, the pulse still ends after 1 cycle.
- All outputs are registered.

## Configuration
- DELAY_SCHED_CANCEL_EN defined:
  - cancel[i] high while grant[i] in LOAD or RUN → FIN on the next enabled edge, with done[i] and aborted pulsed together.
  - cancel on a non-owner is ignored.
- Undefined: the cancel port exists but is unused, and aborted is tied to 0.

## Structure
- Package delay_sched_pkg holds:
  - the state enum (IDLE, LOAD, RUN, FIN);
  - localparam TICK_DIV_10MS = 500_000;
  - the clogb2 function.
- Sub-module tick_prescaler:
  - parameter TICK_DIV;
  - ports CLOCK_50, aclr_n, clear, enable, tick;
  - a mod-TICK_DIV counter with a synchronous clear.
- Arbiter and FSM live in delay_scheduler.

## Test plan
All scenarios use TICK_DIV=4, NREQ=4, DUR_W=8.
- Single request: req[2]=1, dur[2]=3 → grant=0100 next edge; done[2] pulses 1 cycle, 13 edges after grant; remaining steps 3,2,1,0.
- Contention: req=1111, all dur=1 → grants in order 0,1,2,3,0; each done one cycle, one IDLE cycle between owners.
- Zero duration: dur[1]=0 → done[1] on the edge after grant; remaining stays 0.
- Enable pause: dur=2, enable low for 7 cycles mid-RUN → done is delayed by exactly 7 cycles vs. the baseline (9 → 16 edges).
- Reset mid-RUN: assert aclr_n low asynchronously → all outputs 0 immediately. After release, req[3] and req[0] both high → grant goes to 0 first.
- With DELAY_SCHED_CANCEL_EN: dur=10, cancel[owner] after 5 cycles → done and aborted pulse together on the next edge. A cancel on a non-owner has no effect.
